// File: rtl/datapath_wall.sv
// Wall datapath: owns the wall column and the random gap row. On frame-tick step requests
// it erases the current wall column and redraws it one pixel to the left. Pixels go out one
// per cycle on the VGA plot bus. It also flags a player collision and pulses touched after
// the wall has been erased at x = 0.
//
// Ports:
//   clk, reset    single clock; synchronous active-high reset
//   start, move   enables from the wall controller (start wins over move)
//   frame_tick    one-cycle pulse per video frame
//   player_y      player row, used for the collision check at PLAYER_X
//   touched       one-cycle pulse after the erase pass at x = 0
//   hit           sticky collision flag, cleared by start or reset
//   wall_x, gap_y current wall column and top row of the gap
//   plot, x, y, colour  registered VGA pixel write bus
module datapath_wall #(
  parameter int unsigned SCREEN_W        = 160,
  parameter int unsigned SCREEN_H        = 120,
  parameter int unsigned GAP_H           = 30,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned PLAYER_X        = 20,
  parameter logic [2:0]  WALL_COLOUR     = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move,
  input  logic       frame_tick,
  input  logic [6:0] player_y,
  output logic       touched,
  output logic       hit,
  output logic [7:0] wall_x,
  output logic [6:0] gap_y,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour
);

  localparam logic [7:0] XStart  = 8'(SCREEN_W - 1);
  localparam logic [6:0] RowLast = 7'(SCREEN_H - 1);
  localparam logic [7:0] GapMod  = 8'(SCREEN_H - GAP_H + 1);
  localparam logic [7:0] GapSpan = 8'(GAP_H - 1);
  localparam logic [7:0] FcLast  = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] PlayerX = 8'(PLAYER_X);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] wall_x_q, wall_x_d;
  logic [6:0] gap_y_q, gap_y_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       pending_q, pending_d;
  logic [6:0] row_q, row_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       touched_q, touched_d;
  logic       hit_q, hit_d;

  logic [7:0] gap_end;
  logic       row_in_gap;
  logic       player_out;

  // Gap end stays within SCREEN_H-1 because gap_y <= SCREEN_H-GAP_H.
  assign gap_end    = {1'b0, gap_y_q} + GapSpan;
  assign row_in_gap = ({1'b0, row_q} >= {1'b0, gap_y_q}) && ({1'b0, row_q} <= gap_end);
  assign player_out = ({1'b0, player_y} < {1'b0, gap_y_q}) || ({1'b0, player_y} > gap_end);

  always_comb begin
    state_d     = state_q;
    wall_x_d    = wall_x_q;
    gap_y_d     = gap_y_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    row_d       = row_q;
    plot_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    touched_d   = 1'b0;
    hit_d       = hit_q;

    // Step requests; pending saturates so requests during a pass collapse into one.
    if (!move) begin
      pending_d = 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt_q == FcLast) begin
        frame_cnt_d = 8'd0;
        pending_d   = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wall_x_d    = XStart;
          gap_y_d     = 7'(lfsr_q % GapMod);
          frame_cnt_d = 8'd0;
          pending_d   = 1'b0;
          hit_d       = 1'b0;
        end else if (pending_q && move) begin
          pending_d = 1'b0;
          row_d     = 7'd0;
          state_d   = StErase;
        end
      end
      StErase: begin
        plot_d   = 1'b1;
        x_d      = wall_x_q;
        y_d      = row_q;
        colour_d = 3'b000;
        if (row_q == RowLast) begin
          row_d = 7'd0;
          if (wall_x_q == 8'd0) begin
            state_d = StDone;
          end else begin
            wall_x_d = wall_x_q - 8'd1;
            state_d  = StDraw;
            if ((wall_x_q - 8'd1) == PlayerX && player_out) hit_d = 1'b1;
          end
        end else begin
          row_d = row_q + 7'd1;
        end
      end
      StDraw: begin
        plot_d   = 1'b1;
        x_d      = wall_x_q;
        y_d      = row_q;
        colour_d = row_in_gap ? 3'b000 : WALL_COLOUR;
        if (row_q == RowLast) begin
          row_d   = 7'd0;
          state_d = StIdle;
        end else begin
          row_d = row_q + 7'd1;
        end
      end
      StDone: begin
        touched_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wall_x_q    <= XStart;
      gap_y_q     <= 7'd0;
      lfsr_q      <= 8'hA5;
      frame_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
      row_q       <= 7'd0;
      plot_q      <= 1'b0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'b000;
      touched_q   <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wall_x_q    <= wall_x_d;
      gap_y_q     <= gap_y_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      row_q       <= row_d;
      plot_q      <= plot_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      touched_q   <= touched_d;
      hit_q       <= hit_d;
    end
  end

  assign touched = touched_q;
  assign hit     = hit_q;
  assign wall_x  = wall_x_q;
  assign gap_y   = gap_y_q;
  assign plot    = plot_q;
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;

endmodule

// File: tb/tb_datapath_wall.sv
// Directed bench for datapath_wall. Instance a: full screen, PLAYER_X = 157.
// Instance b: 4-pixel-wide screen, one frame tick per step.
module tb_datapath_wall;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Instance a
  logic       a_reset, a_start, a_move, a_tick;
  logic [6:0] a_py;
  logic       a_touched, a_hit, a_plot;
  logic [7:0] a_wall_x, a_x;
  logic [6:0] a_gap_y, a_y;
  logic [2:0] a_colour;

  datapath_wall #(.PLAYER_X(157)) u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .move(a_move), .frame_tick(a_tick),
    .player_y(a_py), .touched(a_touched), .hit(a_hit), .wall_x(a_wall_x), .gap_y(a_gap_y),
    .plot(a_plot), .x(a_x), .y(a_y), .colour(a_colour)
  );

  // Instance b
  logic       b_reset, b_start, b_move, b_tick;
  logic [6:0] b_py;
  logic       b_touched, b_hit, b_plot;
  logic [7:0] b_wall_x, b_x;
  logic [6:0] b_gap_y, b_y;
  logic [2:0] b_colour;

  datapath_wall #(.SCREEN_W(4), .FRAMES_PER_STEP(1)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .move(b_move), .frame_tick(b_tick),
    .player_y(b_py), .touched(b_touched), .hit(b_hit), .wall_x(b_wall_x), .gap_y(b_gap_y),
    .plot(b_plot), .x(b_x), .y(b_y), .colour(b_colour)
  );

  // Reference LFSR for instance a (taps 8,6,5,4, seed A5).
  logic [7:0] ma;
  always @(posedge clk) begin
    if (a_reset) ma <= 8'hA5;
    else         ma <= {ma[6:0], ma[7] ^ ma[5] ^ ma[4] ^ ma[3]};
  end

  logic [6:0] exp_gap;

  task automatic a_do_start();
    a_move  = 1'b0;
    a_start = 1'b1;
    exp_gap = 7'(ma % 8'd91);
    @(negedge clk);
    a_start = 1'b0;
    chk("a_start_gap", a_gap_y, exp_gap);
    chk("a_start_wall_x", a_wall_x, 159);
    chk("a_start_hit", a_hit, 0);
    a_move = 1'b1;
  endtask

  task automatic a_step();
    repeat (4) begin
      a_tick = 1'b1;
      @(negedge clk);
      a_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // Watch one erase+draw pass starting at column xe; optional abort by reset,
  // drop of move, and priming of a pending step before the drop.
  task automatic a_pass(input logic [7:0] xe, input logic [6:0] gp, input logic exp_hit,
                        input int abort_at, input int drop_at, input string tag);
    int bad = 0;
    int t = 0;
    logic [2:0] ec;
    logic [6:0] row;
    while (!a_plot && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_timeout"}, a_plot, 1);
    if (!a_plot) return;
    for (int i = 0; i < 240; i++) begin
      row = 7'(i % 120);
      if (i < 120) ec = 3'b000;
      else ec = (row >= gp && 8'(row) <= 8'(gp) + 8'd29) ? 3'b000 : 3'b010;
      if (a_plot !== 1'b1 || a_x !== ((i < 120) ? xe : xe - 8'd1) || a_y !== row ||
          a_colour !== ec) begin
        if (bad == 0)
          $display("FAIL %s_pixel%0d: got plot=%0d x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   tag, i, a_plot, a_x, a_y, a_colour, (i < 120) ? xe : xe - 8'd1, row, ec);
        bad++;
      end
      if (i == 120) chk({tag, "_hit_on_draw"}, a_hit, exp_hit);
      if (i >= 10 && i <= 16 && drop_at >= 0) a_tick = (i % 2 == 0);
      if (i == drop_at) a_move = 1'b0;
      if (i == abort_at) begin
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        chk({tag, "_abort_plot"}, a_plot, 0);
        chk({tag, "_abort_wall_x"}, a_wall_x, 159);
        chk({tag, "_abort_touched"}, a_touched, 0);
        chk({tag, "_pixels_before_abort"}, bad, 0);
        return;
      end
      @(negedge clk);
    end
    a_tick = 1'b0;
    chk({tag, "_pixels_bad"}, bad, 0);
    chk({tag, "_plot_after"}, a_plot, 0);
    chk({tag, "_wall_x_after"}, a_wall_x, xe - 8'd1);
    chk({tag, "_hit_after"}, a_hit, exp_hit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, nd, no, nt, last_plot, t_touch;
    int runs[8];
    int gaps[8];
    int nrun, cur, gapc;
    logic [7:0] xe;
    logic [6:0] g1;

    a_reset = 1; a_start = 0; a_move = 0; a_tick = 0; a_py = 0;
    b_reset = 1; b_start = 0; b_move = 0; b_tick = 0; b_py = 0;
    repeat (2) @(negedge clk);
    chk("rst_wall_x", a_wall_x, 159);
    chk("rst_plot", a_plot, 0);
    chk("rst_touched", a_touched, 0);
    chk("rst_hit", a_hit, 0);
    chk("rst_xy_colour", {a_x, a_y, a_colour}, 0);
    chk("rst_gap_y", a_gap_y, 0);
    chk("rst_b_wall_x", b_wall_x, 3);
    a_reset = 0; b_reset = 0;
    @(negedge clk);
    chk("idle_no_plot", a_plot, 0);

    // Step and collision: player just above the gap is hit at x = 157.
    a_do_start();
    g1 = exp_gap;
    a_py = 7'd100;
    a_step();
    a_pass(8'd159, g1, 1'b0, -1, -1, "step1");
    a_py = g1 - 7'd1;
    a_step();
    a_pass(8'd158, g1, 1'b1, -1, -1, "step2");

    // Same run with the player inside the gap: no hit.
    a_do_start();
    g1 = exp_gap;
    a_py = g1;
    a_step();
    a_pass(8'd159, g1, 1'b0, -1, -1, "gap1");
    a_step();
    a_pass(8'd158, g1, 1'b0, -1, -1, "gap2");

    // Reset at DRAW row 50.
    a_do_start();
    g1 = exp_gap;
    a_step();
    a_pass(8'd159, g1, 1'b0, 170, -1, "abort");
    ne = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_plot) ne++;
    end
    chk("abort_idle_plots", ne, 0);

    // move drops at DRAW row 50 after a step was already requested.
    a_do_start();
    g1 = exp_gap;
    a_step();
    a_pass(8'd159, g1, 1'b0, -1, 170, "drop");
    ne = 0;
    repeat (300) begin
      @(negedge clk);
      if (a_plot) ne++;
    end
    chk("drop_no_new_pass", ne, 0);
    chk("drop_wall_x", a_wall_x, 158);

    // Narrow screen: passes at 3,2,1 then terminal erase at 0 and one touched pulse.
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    b_move = 1;
    for (int k = 0; k < 4; k++) begin
      xe = 8'(3 - k);
      b_tick = 1;
      @(negedge clk);
      b_tick = 0;
      ne = 0; nd = 0; no = 0; nt = 0; last_plot = 0; t_touch = 0;
      for (int t = 0; t < 299; t++) begin
        @(negedge clk);
        if (b_plot) begin
          if (b_x == xe) ne++;
          else if (xe != 0 && b_x == xe - 8'd1) nd++;
          else no++;
          last_plot = t;
        end
        if (b_touched) begin
          nt++;
          t_touch = t;
        end
      end
      chk($sformatf("edge_x%0d_erase", xe), ne, 120);
      chk($sformatf("edge_x%0d_draw", xe), nd, (xe != 0) ? 120 : 0);
      chk($sformatf("edge_x%0d_other", xe), no, 0);
      chk($sformatf("edge_x%0d_touched", xe), nt, (xe == 0) ? 1 : 0);
      chk($sformatf("edge_x%0d_wall_x", xe), b_wall_x, (xe != 0) ? xe - 8'd1 : 0);
      if (xe == 0) chk("edge_touch_after_last_plot", t_touch - last_plot, 1);
    end

    // Tick every cycle: one step per pass, pass lengths unchanged.
    b_move = 0;
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    b_move = 1;
    b_tick = 1;
    nrun = 0; cur = 0; gapc = 0;
    for (int i = 0; i < 8; i++) begin
      runs[i] = 0;
      gaps[i] = 0;
    end
    for (int t = 0; t < 1100; t++) begin
      @(negedge clk);
      if (b_plot) begin
        if (cur == 0 && nrun > 0 && nrun < 8) gaps[nrun - 1] = gapc;
        cur++;
        gapc = 0;
      end else begin
        if (cur != 0 && nrun < 8) begin
          runs[nrun] = cur;
          nrun++;
        end
        cur = 0;
        gapc++;
      end
    end
    b_tick = 0;
    chk("busy_run0", runs[0], 240);
    chk("busy_run1", runs[1], 240);
    chk("busy_run2", runs[2], 240);
    chk("busy_run3_terminal", runs[3], 120);
    chk("busy_gap0", gaps[0], 1);
    chk("busy_gap1", gaps[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
